// File: rtl/riscv_ctrl_pkg.sv
// Shared control encodings for the RV32I multicycle controller and single-cycle path.
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: n/a.
//
// Contents: FSM state codes, opcode constants, datapath select encodings,
// and a helper that reports whether an opcode is handled by the core.
package riscv_ctrl_pkg;

   // FSM state codes (kept as plain 4-bit constants for legacy tooling)
   typedef logic [3:0] state_t;
   localparam state_t S_FETCH    = 4'd0;
   localparam state_t S_DECODE   = 4'd1;
   localparam state_t S_MEMADR   = 4'd2;
   localparam state_t S_MEMREAD  = 4'd3;
   localparam state_t S_MEMWB    = 4'd4;
   localparam state_t S_MEMWRITE = 4'd5;
   localparam state_t S_EXECUTER = 4'd6;
   localparam state_t S_EXECUTEI = 4'd7;
   localparam state_t S_ALUWB    = 4'd8;
   localparam state_t S_BEQ      = 4'd9;
   localparam state_t S_JAL      = 4'd10;

   // Opcodes (instr[6:0])
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   // ALU operand A select
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   // ALU operand B select
   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // Result bus select
   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   // ALU decoder opcode class
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // Immediate extender format
   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   function automatic logic op_supported(input logic [6:0] op);
      return (op == OP_LOAD)  || (op == OP_STORE)  || (op == OP_RTYPE) ||
             (op == OP_ITYPE) || (op == OP_BRANCH) || (op == OP_JAL);
   endfunction

endpackage

// File: rtl/imm_src_decode.sv
// Immediate-format decode from opcode, shared by the single- and multicycle cores.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
//
// Ports: op (instr[6:0]) in; ImmSrc (I=00, S=01, B=10, J=11) out.
module imm_src_decode
   import riscv_ctrl_pkg::*;
(
   input  logic [6:0] op,
   output logic [1:0] ImmSrc
);

   always_comb begin
      case (op)
         OP_STORE:  ImmSrc = IMM_S;
         OP_BRANCH: ImmSrc = IMM_B;
         OP_JAL:    ImmSrc = IMM_J;
         default:   ImmSrc = IMM_I;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I core: sequences shared ALU, unified memory and regfile.
// Latency: lw 5, sw/R/I/jal 4, beq 3 cycles; +1 per memory wait cycle.
// Backpressure: FETCH/MEMREAD/MEMWRITE hold with outputs stable until mem_ready.
//
// Ports: clk, rst (sync, active high); op, zero, mem_ready in;
// mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ALUSrcA, ALUSrcB,
// ResultSrc, ALUOp, ImmSrc, retire, illegal_op out. All outputs are 0 while rst=1.
module multicycle_controller
   import riscv_ctrl_pkg::*;
#(
   parameter state_t RESET_STATE = S_FETCH
)(
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       MemWrite,
   output logic       AdrSrc,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       RegWrite,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUOp,
   output logic [1:0] ImmSrc,
   output logic       retire,
   output logic       illegal_op
);

   state_t     state, next_state;

   logic       mem_req_c, mem_write_c, adr_src_c, ir_write_c, reg_write_c;
   logic       pc_update_c, branch_c, retire_c, illegal_c;
   logic [1:0] src_a_c, src_b_c, result_src_c, alu_op_c;
   logic [1:0] imm_src_c;

   imm_src_decode u_imm_src_decode (
      .op     (op),
      .ImmSrc (imm_src_c)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= RESET_STATE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state   = state;
      mem_req_c    = 1'b0;
      mem_write_c  = 1'b0;
      adr_src_c    = 1'b0;
      ir_write_c   = 1'b0;
      reg_write_c  = 1'b0;
      pc_update_c  = 1'b0;
      branch_c     = 1'b0;
      retire_c     = 1'b0;
      illegal_c    = 1'b0;
      src_a_c      = SRCA_PC;
      src_b_c      = SRCB_RS2;
      result_src_c = RES_ALUOUT;
      alu_op_c     = ALUOP_ADD;

      case (state)
         S_FETCH: begin
            mem_req_c    = 1'b1;
            src_b_c      = SRCB_FOUR;
            result_src_c = RES_ALURESULT;
            // PC+4 and the instruction are only captured once memory delivers
            if (mem_ready) begin
               ir_write_c  = 1'b1;
               pc_update_c = 1'b1;
               next_state  = S_DECODE;
            end
         end
         S_DECODE: begin
            // ALU computes OldPC+imm here so the branch/jump target is ready in ALUOut
            src_a_c = SRCA_OLDPC;
            src_b_c = SRCB_IMM;
            case (op)
               OP_LOAD, OP_STORE: next_state = S_MEMADR;
               OP_RTYPE:          next_state = S_EXECUTER;
               OP_ITYPE:          next_state = S_EXECUTEI;
               OP_BRANCH:         next_state = S_BEQ;
               OP_JAL:            next_state = S_JAL;
               default: begin
                  illegal_c  = 1'b1;
                  next_state = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            src_a_c    = SRCA_RS1;
            src_b_c    = SRCB_IMM;
            next_state = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            mem_req_c = 1'b1;
            adr_src_c = 1'b1;
            if (mem_ready)
               next_state = S_MEMWB;
         end
         S_MEMWB: begin
            result_src_c = RES_DATA;
            reg_write_c  = 1'b1;
            retire_c     = 1'b1;
            next_state   = S_FETCH;
         end
         S_MEMWRITE: begin
            mem_req_c   = 1'b1;
            mem_write_c = 1'b1;
            adr_src_c   = 1'b1;
            if (mem_ready) begin
               retire_c   = 1'b1;
               next_state = S_FETCH;
            end
         end
         S_EXECUTER: begin
            src_a_c    = SRCA_RS1;
            src_b_c    = SRCB_RS2;
            alu_op_c   = ALUOP_FUNCT;
            next_state = S_ALUWB;
         end
         S_EXECUTEI: begin
            src_a_c    = SRCA_RS1;
            src_b_c    = SRCB_IMM;
            alu_op_c   = ALUOP_FUNCT;
            next_state = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write_c = 1'b1;
            retire_c    = 1'b1;
            next_state  = S_FETCH;
         end
         S_BEQ: begin
            src_a_c    = SRCA_RS1;
            src_b_c    = SRCB_RS2;
            alu_op_c   = ALUOP_SUB;
            branch_c   = 1'b1;
            retire_c   = 1'b1;
            next_state = S_FETCH;
         end
         S_JAL: begin
            // ALU forms OldPC+4 for the link write in ALUWB; PC takes the target from ALUOut
            src_a_c     = SRCA_OLDPC;
            src_b_c     = SRCB_FOUR;
            pc_update_c = 1'b1;
            next_state  = S_ALUWB;
         end
         default: begin
            next_state = S_FETCH;
         end
      endcase
   end

   // Reset blanks every output combinationally so nothing escapes during the reset cycles
   always_comb begin
      mem_req    = mem_req_c   & ~rst;
      MemWrite   = mem_write_c & ~rst;
      AdrSrc     = adr_src_c   & ~rst;
      IRWrite    = ir_write_c  & ~rst;
      PCWrite    = (pc_update_c | (branch_c & zero)) & ~rst;
      RegWrite   = reg_write_c & ~rst;
      retire     = retire_c    & ~rst;
      illegal_op = illegal_c   & ~rst;
      ALUSrcA    = rst ? 2'b00 : src_a_c;
      ALUSrcB    = rst ? 2'b00 : src_b_c;
      ResultSrc  = rst ? 2'b00 : result_src_c;
      ALUOp      = rst ? 2'b00 : alu_op_c;
      ImmSrc     = rst ? 2'b00 : imm_src_c;
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle comparison against an
// instruction-level step model, directed cycle-count checks and randomized traffic.
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       rst, zero, mem_ready;
   logic [6:0] op;
   logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, retire, illegal_op;
   logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALUOp, ImmSrc;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   multicycle_controller dut (
      .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
      .PCWrite(PCWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ResultSrc(ResultSrc), .ALUOp(ALUOp), .ImmSrc(ImmSrc), .retire(retire),
      .illegal_op(illegal_op)
   );

   typedef struct packed {
      logic mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, retire, illegal_op;
      logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALUOp, ImmSrc;
   } ctl_t;

   ctl_t act;
   assign act = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, retire, illegal_op,
                 ALUSrcA, ALUSrcB, ResultSrc, ALUOp, ImmSrc};

   // Instruction steps as named in the control description
   localparam int F = 0, D = 1, MA = 2, MR = 3, MWB = 4, MW = 5;
   localparam int ER = 6, EI = 7, AWB = 8, BQ = 9, JL = 10;

   task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
      tests++;
      if (a !== e) begin
         failed++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, a, e, $time);
      end
   endtask

   // Expected control word for one cycle of a step, derived from the control table
   function automatic ctl_t ctrl_of(input int s, input logic [6:0] o, input logic mr, input logic z);
      ctl_t c = '0;
      c.ImmSrc = (o == 7'b0100011) ? 2'b01 :
                 (o == 7'b1100011) ? 2'b10 :
                 (o == 7'b1101111) ? 2'b11 : 2'b00;
      case (s)
         F:   begin c.mem_req = 1; c.ALUSrcB = 2'b10; c.ResultSrc = 2'b10;
                    c.IRWrite = mr; c.PCWrite = mr; end
         D:   begin c.ALUSrcA = 2'b01; c.ALUSrcB = 2'b01;
                    c.illegal_op = !(o inside {7'b0000011, 7'b0100011, 7'b0110011,
                                                7'b0010011, 7'b1100011, 7'b1101111}); end
         MA:  begin c.ALUSrcA = 2'b10; c.ALUSrcB = 2'b01; end
         MR:  begin c.mem_req = 1; c.AdrSrc = 1; end
         MWB: begin c.ResultSrc = 2'b01; c.RegWrite = 1; c.retire = 1; end
         MW:  begin c.mem_req = 1; c.MemWrite = 1; c.AdrSrc = 1; c.retire = mr; end
         ER:  begin c.ALUSrcA = 2'b10; c.ALUOp = 2'b10; end
         EI:  begin c.ALUSrcA = 2'b10; c.ALUSrcB = 2'b01; c.ALUOp = 2'b10; end
         AWB: begin c.RegWrite = 1; c.retire = 1; end
         BQ:  begin c.ALUSrcA = 2'b10; c.ALUOp = 2'b01; c.PCWrite = z; c.retire = 1; end
         JL:  begin c.ALUSrcA = 2'b01; c.ALUSrcB = 2'b10; c.PCWrite = 1; end
         default: c = '0;
      endcase
      return c;
   endfunction

   // Runs one instruction from FETCH to its last cycle, checking every cycle.
   // zmode: 0/1 constant zero, 2 random. Non-waiting steps get random mem_ready.
   task automatic run_instr(input logic [6:0] o, input int wf, input int wm, input int zmode,
                            output int ret_cyc, output int mw_cnt, output int total,
                            output int pcw_cnt, output int rw_cnt, output int il_cnt,
                            output logic [1:0] imm_last);
      int   steps[$];
      int   si = 0, wcnt = 0, waits;
      logic mr;
      case (o)
         7'b0000011: steps = '{F, D, MA, MR, MWB};
         7'b0100011: steps = '{F, D, MA, MW};
         7'b0110011: steps = '{F, D, ER, AWB};
         7'b0010011: steps = '{F, D, EI, AWB};
         7'b1100011: steps = '{F, D, BQ};
         7'b1101111: steps = '{F, D, JL, AWB};
         default:    steps = '{F, D};
      endcase
      ret_cyc = 0; mw_cnt = 0; total = 0; pcw_cnt = 0; rw_cnt = 0; il_cnt = 0; imm_last = 2'b00;
      while (si < steps.size()) begin
         @(negedge clk);
         op    = o;
         zero  = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
         waits = (steps[si] == F) ? wf : wm;
         if (steps[si] inside {F, MR, MW})
            mr = (wcnt >= waits);
         else
            mr = 1'($urandom_range(0, 1));
         mem_ready = mr;
         #1;
         total++;
         check($sformatf("ctl op=%b step=%0d", o, steps[si]), 32'(act),
               32'(ctrl_of(steps[si], o, mr, zero)));
         if (retire)     ret_cyc = total;
         if (MemWrite)   mw_cnt++;
         if (PCWrite)    pcw_cnt++;
         if (RegWrite)   rw_cnt++;
         if (illegal_op) il_cnt++;
         imm_last = ImmSrc;
         if ((steps[si] inside {F, MR, MW}) && !mr)
            wcnt++;
         else begin
            si++;
            wcnt = 0;
         end
      end
   endtask

   initial begin
      int r, m, t, p, rw, il;
      logic [1:0] im;
      logic [6:0] ops[7];
      ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111, 7'b0000000};

      rst = 1; op = 7'b0; mem_ready = 0; zero = 0;
      @(negedge clk); #1 check("reset_cycle0", 32'(act), 32'd0);
      @(negedge clk); #1 check("reset_cycle1", 32'(act), 32'd0);
      @(negedge clk);
      rst = 0; mem_ready = 0;
      #1 check("post_reset_fetch", 32'(act), 32'(ctrl_of(F, 7'b0, 1'b0, 1'b0)));

      // lw, no waits
      run_instr(7'b0000011, 0, 0, 0, r, m, t, p, rw, il, im);
      check("lw_total", t, 5); check("lw_retire_cyc", r, 5); check("lw_regwrite", rw, 1);
      // sw, three wait cycles in MEMWRITE
      run_instr(7'b0100011, 0, 3, 0, r, m, t, p, rw, il, im);
      check("sw_total", t, 7); check("sw_retire_cyc", r, 7);
      check("sw_memwrite_cycles", m, 4); check("sw_immsrc", 32'(im), 1);
      // R-type and I-type (with two fetch waits)
      run_instr(7'b0110011, 0, 0, 0, r, m, t, p, rw, il, im);
      check("rtype_total", t, 4);
      run_instr(7'b0010011, 2, 0, 0, r, m, t, p, rw, il, im);
      check("itype_total_2wait", t, 6);
      // beq taken and not taken
      run_instr(7'b1100011, 0, 0, 1, r, m, t, p, rw, il, im);
      check("beq_taken_total", t, 3); check("beq_taken_pcwrite", p, 2);
      run_instr(7'b1100011, 0, 0, 0, r, m, t, p, rw, il, im);
      check("beq_nottaken_total", t, 3); check("beq_nottaken_pcwrite", p, 1);
      // jal
      run_instr(7'b1101111, 0, 0, 0, r, m, t, p, rw, il, im);
      check("jal_total", t, 4); check("jal_pcwrite", p, 2);
      check("jal_regwrite", rw, 1); check("jal_immsrc", 32'(im), 3);
      // illegal opcode
      run_instr(7'b1111111, 0, 0, 0, r, m, t, p, rw, il, im);
      check("illegal_total", t, 2); check("illegal_pulse", il, 1);
      check("illegal_no_retire", r, 0); check("illegal_no_write", rw + m, 0);

      // Reset held for two cycles while in EXECUTER
      @(negedge clk); op = 7'b0110011; mem_ready = 1; zero = 0;
      @(negedge clk);
      @(negedge clk); #1 check("pre_reset_executer", 32'(act),
                               32'(ctrl_of(ER, 7'b0110011, 1'b1, 1'b0)));
      rst = 1;
      #1 check("midreset_a", 32'(act), 32'd0);
      @(negedge clk); #1 check("midreset_b", 32'(act), 32'd0);
      @(negedge clk);
      rst = 0; mem_ready = 0;
      #1 check("after_midreset_fetch", 32'(act), 32'(ctrl_of(F, 7'b0110011, 1'b0, 1'b0)));
      run_instr(7'b0110011, 1, 0, 0, r, m, t, p, rw, il, im);
      check("after_midreset_rtype_total", t, 5);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         logic [6:0] o;
         o = ops[$urandom_range(0, 6)];
         if (o == 7'b0000000) o = 7'($urandom);
         run_instr(o, $urandom_range(0, 3), $urandom_range(0, 3), 2, r, m, t, p, rw, il, im);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
